// File: rtl/conv3x3_scan_ctrl.sv
// conv3x3_scan_ctrl: raster-scan sequencer for a 3x3 stride-1 convolution.
// Optional window counter / count check enabled by CONV3X3_SCAN_CTRL_WIN_CNT_EN.
module conv3x3_scan_ctrl #(
    parameter int IMG_W     = 100,
    parameter int IMG_H     = 100,
    parameter int CNT_WIDTH = 14
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    output logic                   Shift_En,
    output logic                   Win_Valid,
    output logic [CNT_WIDTH-1:0]   Row_Idx,
    output logic [CNT_WIDTH-1:0]   Col_Idx,
    output logic                   Busy,
    output logic                   Done
`ifdef CONV3X3_SCAN_CTRL_WIN_CNT_EN
    ,
    output logic [2*CNT_WIDTH-1:0] Win_Count,
    output logic                   Count_Err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(IMG_W - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(IMG_H - 1);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic                 win_q, win_d;
    logic                 accept;

    assign In_Ready  = (state_q == RUN);
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == FIN);
    assign accept    = In_Valid & In_Ready;
    assign Shift_En  = accept;
    assign Win_Valid = win_q;
    assign Row_Idx   = row_q;
    assign Col_Idx   = col_q;

    // Next state, scan position and window flag for the pixel accepted now
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        win_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    win_d = (row_q >= TWO) && (col_q >= TWO) && !Abort;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = FIN;
                        end else begin
                            row_d = row_q + ONE;
                        end
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
                if (Abort) begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered window flag
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
        end
    end

`ifdef CONV3X3_SCAN_CTRL_WIN_CNT_EN
    localparam int CW2 = 2 * CNT_WIDTH;
    localparam logic [CW2-1:0] WIN_TOTAL = CW2'((IMG_W - 2) * (IMG_H - 2));

    logic [CW2-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [CW2-1:0] win_ext;

    assign win_ext   = {{(CW2 - 1){1'b0}}, win_q};
    assign Win_Count = cnt_q;
    assign Count_Err = err_q;

    // Window tally for the frame and end-of-frame consistency check
    always_comb begin
        cnt_d = cnt_q + win_ext;
        err_d = err_q;
        if (state_q == FIN) begin
            err_d = ((cnt_q + win_ext) != WIN_TOTAL);
        end
        if ((state_q == IDLE) && Start) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    // Window tally registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_conv3x3_scan_ctrl.sv
// tb_conv3x3_scan_ctrl: directed and random frames against a
// frame-level model of the 3x3 scan controller (IMG_W=5, IMG_H=4).
module tb_conv3x3_scan_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = 14;
    localparam int NWIN = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic          win_valid;
    logic [CW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          busy;
    logic          done;
`ifdef CONV3X3_SCAN_CTRL_WIN_CNT_EN
    logic [2*CW-1:0] win_count;
    logic            count_err;
`endif

    conv3x3_scan_ctrl #(
        .IMG_W(W),
        .IMG_H(H),
        .CNT_WIDTH(CW)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .Start(start),
        .Abort(abort),
        .In_Valid(in_valid),
        .In_Ready(in_ready),
        .Shift_En(shift_en),
        .Win_Valid(win_valid),
        .Row_Idx(row_idx),
        .Col_Idx(col_idx),
        .Busy(busy),
        .Done(done)
`ifdef CONV3X3_SCAN_CTRL_WIN_CNT_EN
        ,
        .Win_Count(win_count),
        .Count_Err(count_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Frame-level model: pixels accepted so far in the frame.
    bit m_run = 0;
    bit m_fin = 0;
    bit m_win = 0;
    int m_n   = 0;
    int m_cnt = 0;
    bit m_err = 0;

    int win_seen  = 0;
    int done_seen = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit s, bit a, bit v, bit r = 1'b0);
        int p;
        bit nw;
        @(negedge clk);
        start    = s;
        abort    = a;
        in_valid = v;
        rst      = r;
        #1;
        check("in_ready", 32'(in_ready), 32'(m_run));
        check("busy", 32'(busy), 32'(m_run | m_fin));
        check("done", 32'(done), 32'(m_fin));
        check("shift_en", 32'(shift_en), 32'(m_run & v));
        check("win_valid", 32'(win_valid), 32'(m_win));
        check("row_idx", 32'(row_idx), m_run ? 32'(m_n / W) : 32'd0);
        check("col_idx", 32'(col_idx), m_run ? 32'(m_n % W) : 32'd0);
`ifdef CONV3X3_SCAN_CTRL_WIN_CNT_EN
        check("win_count", 32'(win_count), 32'(m_cnt));
        check("count_err", 32'(count_err), 32'(m_err));
`endif
        win_seen  += int'(win_valid);
        done_seen += int'(done);
        @(posedge clk);
        if (r) begin
            m_run = 0; m_fin = 0; m_win = 0;
            m_n = 0; m_cnt = 0; m_err = 0;
        end else begin
            nw = 0;
            if (m_fin) m_err = ((m_cnt + int'(m_win)) != NWIN);
            m_cnt += int'(m_win);
            if (m_fin) begin
                m_fin = 0;
            end else if (m_run) begin
                if (v) begin
                    p  = m_n;
                    nw = (p / W >= 2) && (p % W >= 2) && !a;
                    m_n++;
                end
                if (a) begin
                    m_run = 0; m_n = 0;
                end else if (m_n == W * H) begin
                    m_run = 0; m_fin = 1; m_n = 0;
                end
            end else if (s) begin
                m_run = 1; m_n = 0; m_cnt = 0; m_err = 0;
            end
            m_win = nw;
        end
    endtask

    // Start, feed W*H pixels (with a gap after each when gap=1), then idle.
    task automatic frame(bit gap, bit hold_start);
        win_seen  = 0;
        done_seen = 0;
        step(1, 0, 0);
        for (int i = 0; i < W * H; i++) begin
            step(hold_start, 0, 1);
            if (gap) step(hold_start, 0, 0);
        end
        step(hold_start, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("frame_wins", 32'(win_seen), 32'(NWIN));
        check("frame_done", 32'(done_seen), 32'd1);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 1);

        frame(0, 0);
        frame(1, 0);
`ifdef CONV3X3_SCAN_CTRL_WIN_CNT_EN
        check("final_count", 32'(win_count), 32'(NWIN));
        check("final_err", 32'(count_err), 32'd0);
`endif

        done_seen = 0;
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        check("abort_done", 32'(done_seen), 32'd0);
        frame(0, 0);

        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0);
        frame(0, 0);

        frame(0, 1);

        step(1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 299) == 0));
        end
        step(0, 0, 0);
        step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
